boot_rom_axil_slave: RTL and testbench

AXI4-Lite slave front-end for the boot ROM: accepts read transactions from the SoC AXI interconnect, drives the ROM's chip-select/word-address port and returns the fetched word on the R channel. Writes are rejected with SLVERR without touching the ROM. It sits between the interconnect's boot-ROM address window and the `boot_code` macro, which registers its address on `CLK` when `CSN` is low.

---
 rtl/boot_rom_pkg.sv | 32 +++
 rtl/boot_rom_axil_slave_if.sv | 39 +++
 rtl/boot_rom_wr_err.sv | 69 ++++++
 rtl/boot_rom_axil_slave.sv | 92 +++++++++
 tb/tb_boot_rom_axil_slave.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_rom_pkg.sv
// Shared constants, response codes, FSM state types and the R-channel payload
// for the boot ROM AXI4-Lite front-end.
package boot_rom_pkg;

    localparam int unsigned ROM_AW    = 10;
    localparam int unsigned ROM_WORDS = 548;
    localparam int unsigned DATA_W    = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACCESS,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        axi_resp_t         resp;
    } rd_beat_t;

endpackage

// File: rtl/boot_rom_axil_slave_if.sv
// AXI4-Lite bus between the interconnect (master) and the boot ROM front-end (slave).
interface boot_rom_axil_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    import boot_rom_pkg::*;

    logic [ADDR_WIDTH-1:0] ar_addr;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [DATA_W-1:0]     r_data;
    logic [1:0]            r_resp;
    logic                  r_valid;
    logic                  r_ready;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic                  aw_valid;
    logic                  aw_ready;
    logic [DATA_W-1:0]     w_data;
    logic [DATA_W/8-1:0]   w_strb;
    logic                  w_valid;
    logic                  w_ready;
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  b_ready;

    modport slave (
        input  ar_addr, ar_valid, r_ready, aw_addr, aw_valid,
               w_data, w_strb, w_valid, b_ready,
        output ar_ready, r_data, r_resp, r_valid, aw_ready, w_ready,
               b_resp, b_valid
    );

    modport master (
        output ar_addr, ar_valid, r_ready, aw_addr, aw_valid,
               w_data, w_strb, w_valid, b_ready,
        input  ar_ready, r_data, r_resp, r_valid, aw_ready, w_ready,
               b_resp, b_valid
    );

endinterface

// File: rtl/boot_rom_wr_err.sv
// Write-channel error responder: accepts AW and W in any order and answers SLVERR.
module boot_rom_wr_err
    import boot_rom_pkg::*;
(
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       aw_valid,
    output logic       aw_ready,
    input  logic       w_valid,
    output logic       w_ready,
    output logic [1:0] b_resp,
    output logic       b_valid,
    input  logic       b_ready
);

    wr_state_t wr_state;
    logic      aw_hs;
    logic      w_hs;
    logic      both_done;

    assign aw_hs = aw_valid && aw_ready;
    assign w_hs  = w_valid && w_ready;

    // The second half of the address/data pair has just been accepted.
    assign both_done = ((wr_state == W_IDLE) && aw_hs && w_hs) ||
                       ((wr_state == W_HAVE_AW) && w_hs) ||
                       ((wr_state == W_HAVE_W) && aw_hs);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_state <= W_IDLE;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= OKAY;
        end else if (both_done) begin
            wr_state <= W_RESP;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b1;
            b_resp   <= SLVERR;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    aw_ready <= 1'b1;
                    w_ready  <= 1'b1;
                    if (aw_hs) begin
                        wr_state <= W_HAVE_AW;
                        aw_ready <= 1'b0;
                    end else if (w_hs) begin
                        wr_state <= W_HAVE_W;
                        w_ready  <= 1'b0;
                    end
                end
                W_HAVE_AW, W_HAVE_W: ;
                W_RESP: begin
                    if (b_ready) begin
                        wr_state <= W_IDLE;
                        b_valid  <= 1'b0;
                        aw_ready <= 1'b1;
                        w_ready  <= 1'b1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/boot_rom_axil_slave.sv
// AXI4-Lite read front-end for the boot_code ROM macro; writes go to the
// SLVERR responder.
module boot_rom_axil_slave
    import boot_rom_pkg::*;
(
    input  logic              CLK,
    input  logic              RSTN,
    boot_rom_axil_slave_if.slave bus,
    output logic              rom_csn,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata
);

    rd_state_t         rd_state;
    logic              ar_ready_q;
    logic              r_valid_q;
    logic              err_q;
    rd_beat_t          r_beat_q;
    logic [ROM_AW-1:0] ar_index;
    logic              ar_hs;
    logic              ar_in_range;
    logic              unused_bus;

    assign ar_index    = bus.ar_addr[ROM_AW+1:2];
    assign ar_hs       = (rd_state == R_IDLE) && ar_ready_q && bus.ar_valid;
    assign ar_in_range = ar_index < ROM_AW'(ROM_WORDS);

    // ROM address is presented in the accept cycle so data arrives during R_ACCESS.
    assign rom_csn  = !(ar_hs && ar_in_range);
    assign rom_addr = (ar_hs && ar_in_range) ? ar_index : '0;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_state   <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            r_beat_q   <= '{data: '0, resp: OKAY};
        end else begin
            case (rd_state)
                R_IDLE: begin
                    ar_ready_q <= 1'b1;
                    if (ar_hs) begin
                        ar_ready_q <= 1'b0;
                        err_q      <= !ar_in_range;
                        rd_state   <= R_ACCESS;
                    end
                end
                R_ACCESS: begin
                    if (err_q) begin
                        r_beat_q.data <= '0;
                        r_beat_q.resp <= SLVERR;
                    end else begin
                        r_beat_q.data <= rom_rdata;
                        r_beat_q.resp <= OKAY;
                    end
                    r_valid_q <= 1'b1;
                    rd_state  <= R_RESP;
                end
                R_RESP: begin
                    if (bus.r_ready) begin
                        r_valid_q  <= 1'b0;
                        ar_ready_q <= 1'b1;
                        rd_state   <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign bus.ar_ready = ar_ready_q;
    assign bus.r_valid  = r_valid_q;
    assign bus.r_data   = r_beat_q.data;
    assign bus.r_resp   = r_beat_q.resp;

    boot_rom_wr_err u_wr_err (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .aw_valid (bus.aw_valid),
        .aw_ready (bus.aw_ready),
        .w_valid  (bus.w_valid),
        .w_ready  (bus.w_ready),
        .b_resp   (bus.b_resp),
        .b_valid  (bus.b_valid),
        .b_ready  (bus.b_ready)
    );

    // Write payload and upper/lower address bits carry no meaning here.
    assign unused_bus = ^{bus.ar_addr, bus.aw_addr, bus.w_data, bus.w_strb};

endmodule

// File: tb/tb_boot_rom_axil_slave.sv
// Bench for boot_rom_axil_slave: transaction-level model checked every cycle
// plus directed reads/writes with literal expectations.
module tb_boot_rom_axil_slave;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        rom_csn;
    logic [9:0]  rom_addr;
    logic [31:0] rom_rdata;
    logic [31:0] rom_q = '0;
    logic [31:0] rom_mem [0:1023];

    int checks = 0;
    int errors = 0;

    boot_rom_axil_slave_if #(.ADDR_WIDTH(32)) bus ();

    boot_rom_axil_slave dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .bus       (bus),
        .rom_csn   (rom_csn),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata)
    );

    always #5 CLK = ~CLK;

    // boot_code macro: address registered while CSN is low, output otherwise held
    always @(posedge CLK) if (!rom_csn) rom_q <= rom_mem[rom_addr];
    assign rom_rdata = rom_q;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Transaction model: pending read responses with due cycle, write bookkeeping
    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          due;
    } rexp_t;

    rexp_t rq[$];
    int    cyc = 0;
    bit    alive = 0;
    bit    aw_got = 0, w_got = 0, b_pend = 0;

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rq.delete();
            alive  = 0;
            aw_got = 0;
            w_got  = 0;
            b_pend = 0;
        end else begin
            if (!alive) begin
                alive = 1;
            end else begin
                bit    arr, awr, wrr;
                int    idx;
                rexp_t e;
                arr = (rq.size() == 0);
                awr = !aw_got && !b_pend;
                wrr = !w_got && !b_pend;
                if (rq.size() > 0 && cyc >= rq[0].due && bus.r_ready) void'(rq.pop_front());
                if (arr && bus.ar_valid) begin
                    idx = int'(bus.ar_addr[11:2]);
                    e.due = cyc + 2;
                    if (idx >= 548) begin e.data = '0; e.resp = 2'b10; end
                    else begin e.data = rom_mem[idx]; e.resp = 2'b00; end
                    rq.push_back(e);
                end
                if (b_pend && bus.b_ready) b_pend = 0;
                if (awr && bus.aw_valid) aw_got = 1;
                if (wrr && bus.w_valid) w_got = 1;
                if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
            end
            cyc++;
        end
    end

    always @(negedge CLK) begin
        if (!RSTN) begin
            chk("rst_ar_ready", 32'(bus.ar_ready), 0);
            chk("rst_aw_ready", 32'(bus.aw_ready), 0);
            chk("rst_w_ready", 32'(bus.w_ready), 0);
            chk("rst_r_valid", 32'(bus.r_valid), 0);
            chk("rst_r_data", bus.r_data, 0);
            chk("rst_r_resp", 32'(bus.r_resp), 0);
            chk("rst_b_valid", 32'(bus.b_valid), 0);
            chk("rst_b_resp", 32'(bus.b_resp), 0);
            chk("rst_rom_csn", 32'(rom_csn), 1);
            chk("rst_rom_addr", 32'(rom_addr), 0);
        end else begin
            bit ear, ecs, erv;
            int idx;
            idx = int'(bus.ar_addr[11:2]);
            ear = alive && rq.size() == 0;
            ecs = !(ear && bus.ar_valid && idx < 548);
            erv = rq.size() > 0 && cyc >= rq[0].due;
            chk("m_ar_ready", 32'(bus.ar_ready), 32'(ear));
            chk("m_rom_csn", 32'(rom_csn), 32'(ecs));
            if (!ecs) chk("m_rom_addr", 32'(rom_addr), 32'(idx));
            chk("m_r_valid", 32'(bus.r_valid), 32'(erv));
            if (erv) begin
                chk("m_r_data", bus.r_data, rq[0].data);
                chk("m_r_resp", 32'(bus.r_resp), 32'(rq[0].resp));
            end
            chk("m_aw_ready", 32'(bus.aw_ready), 32'(alive && !aw_got && !b_pend));
            chk("m_w_ready", 32'(bus.w_ready), 32'(alive && !w_got && !b_pend));
            chk("m_b_valid", 32'(bus.b_valid), 32'(b_pend));
            if (b_pend) chk("m_b_resp", 32'(bus.b_resp), 2);
        end
    end

    task automatic do_read(input logic [31:0] addr, input int stall,
                           input logic [31:0] exp_d, input logic [1:0] exp_r, input string nm);
        int t;
        int lat;
        bus.ar_addr  = addr;
        bus.ar_valid = 1'b1;
        bus.r_ready  = (stall == 0);
        t = 0;
        do begin @(negedge CLK); t++; end while (!bus.ar_ready && t < 50);
        chk({nm, "_ar_wait"}, 32'(t < 50), 1);
        @(posedge CLK); #1;
        bus.ar_valid = 1'b0;
        lat = 0;
        do begin @(negedge CLK); lat++; end while (!bus.r_valid && lat < 50);
        chk({nm, "_latency"}, 32'(lat), 2);
        chk({nm, "_data"}, bus.r_data, exp_d);
        chk({nm, "_resp"}, 32'(bus.r_resp), 32'(exp_r));
        if (stall > 0) begin
            repeat (stall) @(negedge CLK);
            chk({nm, "_stall_data"}, bus.r_data, exp_d);
            chk({nm, "_stall_ar_ready"}, 32'(bus.ar_ready), 0);
            @(posedge CLK); #1;
            bus.r_ready = 1'b1;
        end
        @(posedge CLK); #1;
    endtask

    task automatic do_write(input int w_lead, input string nm);
        int t;
        bus.aw_addr = 32'h0000_0100;
        bus.w_data  = $urandom;
        bus.w_strb  = 4'hF;
        if (w_lead == 0) begin
            bus.aw_valid = 1'b1;
            bus.w_valid  = 1'b1;
            t = 0;
            do begin @(negedge CLK); t++; end while (!(bus.aw_ready && bus.w_ready) && t < 50);
            chk({nm, "_aww_wait"}, 32'(t < 50), 1);
            @(posedge CLK); #1;
            bus.aw_valid = 1'b0;
            bus.w_valid  = 1'b0;
        end else begin
            bus.w_valid = 1'b1;
            t = 0;
            do begin @(negedge CLK); t++; end while (!bus.w_ready && t < 50);
            chk({nm, "_w_wait"}, 32'(t < 50), 1);
            @(posedge CLK); #1;
            bus.w_valid = 1'b0;
            repeat (w_lead) @(posedge CLK);
            #1;
            bus.aw_valid = 1'b1;
            t = 0;
            do begin @(negedge CLK); t++; end while (!bus.aw_ready && t < 50);
            chk({nm, "_aw_wait"}, 32'(t < 50), 1);
            @(posedge CLK); #1;
            bus.aw_valid = 1'b0;
        end
        @(negedge CLK);
        chk({nm, "_b_valid"}, 32'(bus.b_valid), 1);
        chk({nm, "_b_resp"}, 32'(bus.b_resp), 2);
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int t;
        for (int i = 0; i < 1024; i++) rom_mem[i] = 32'h0BAD_C000 ^ 32'(i);
        rom_mem[0]  = 32'h0000_0013;
        rom_mem[1]  = 32'h0000_0013;
        rom_mem[31] = 32'h0100_006F;

        bus.ar_addr = '0; bus.ar_valid = 1'b0; bus.r_ready = 1'b1;
        bus.aw_addr = '0; bus.aw_valid = 1'b0;
        bus.w_data  = '0; bus.w_strb = '0; bus.w_valid = 1'b0;
        bus.b_ready = 1'b1;

        repeat (3) @(posedge CLK);
        #1 RSTN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        do_read(32'h0000_0000, 0, 32'h0000_0013, 2'b00, "rd_w0");
        do_read(32'h0000_007C, 5, 32'h0100_006F, 2'b00, "rd_stall");
        do_read(32'h0000_0890, 0, 32'h0000_0000, 2'b10, "rd_oor548");
        do_read(32'h0000_088C, 0, 32'h0BAD_C223, 2'b00, "rd_last547");
        do_read(32'h0000_0FFC, 0, 32'h0000_0000, 2'b10, "rd_oor1023");
        do_read(32'hFFFF_F007, 0, 32'h0000_0013, 2'b00, "rd_ignbits");

        do_write(0, "wr_same");
        do_write(3, "wr_wfirst");

        fork
            do_read(32'h0000_007C, 0, 32'h0100_006F, 2'b00, "par_rd");
            do_write(0, "par_wr");
        join

        // abort a read while the ROM access is in flight
        bus.ar_addr  = 32'h0000_0004;
        bus.ar_valid = 1'b1;
        t = 0;
        do begin @(negedge CLK); t++; end while (!bus.ar_ready && t < 50);
        chk("rst_ar_wait", 32'(t < 50), 1);
        @(posedge CLK); #1;
        bus.ar_valid = 1'b0;
        RSTN = 1'b0;
        @(negedge CLK);
        chk("abort_csn", 32'(rom_csn), 1);
        repeat (2) @(posedge CLK);
        #1 RSTN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("abort_no_rvalid", 32'(bus.r_valid), 0);
        end
        chk("abort_ar_ready", 32'(bus.ar_ready), 1);
        @(posedge CLK); #1;
        do_read(32'h0000_0004, 0, 32'h0000_0013, 2'b00, "rd_after_rst");

        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
